dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder on the memory-stage side of the pipeline.
//  Accepts load/store requests from the EX/MEM register (mem_read, mem_write, address, write_data).
//  Holds the pipeline with a stall handshake for a programmable access latency.
//  Returns load data registered, in the cycle the stall drops.
// PARAMETERS
//  DATA_WIDTH  32  word width in bits
//  ADDR_WIDTH  10  word-address bits; depth = 2**ADDR_WIDTH words
//  LATENCY     2   array access cycles, >=1; stall length = LATENCY+1 cycles
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  mem_read    in   1           load request from EX/MEM
//  mem_write   in   1           store request from EX/MEM
//  address     in   32          byte address; word index = address[ADDR_WIDTH+1:2]
//  write_data  in   DATA_WIDTH  store data
//  read_data   out  DATA_WIDTH  load result, registered
//  stall       out  1           high = hold PC, IF/ID, ID/EX, EX/MEM; MEM/WB must not load
//  misalign    out  1           sticky: request seen with address[1:0]!=0
//  conflict    out  1           sticky: mem_read and mem_write high together
// BEHAVIOUR
//  - Reset (sync, active-high):
//    - state=IDLE, cnt=0; read_data, stall, misalign, conflict all 0.
//    - Whole array cleared to 0.
//    - Any in-flight access is dropped; a pending store is never written.
//  - req = mem_read | mem_write.
//  - stall is combinational: req && state!=DONE.
//  - FSM states:
//    - IDLE: on req, latch {rd, wr, index, wdata}, cnt<=LATENCY-1, go ACCESS. Without req, stay.
//    - ACCESS: if cnt!=0, cnt<=cnt-1. If cnt==0, perform the access and go DONE.
//      - Latched rd: read_data <= mem[index].
//      - Latched wr: mem[index] <= wdata.
//    - DONE: stall=0 and read_data is valid. The pipeline advances at this edge; go IDLE.
//  - Latency: a request first seen in IDLE in cycle N has stall high in cycles N..N+LATENCY.
//    It completes with stall low in cycle N+LATENCY+1.
//  - Back-to-back requests: a new req in the cycle after DONE is a new request; IDLE latches it.
//    There is no dead cycle beyond IDLE.
//  - Latched copies are used after IDLE; input changes while stalled are ignored.
//  - read_data holds its last load value through stores and idle cycles. It changes only on a load access.
//  - Both mem_read and mem_write high: treated as a store (write wins), read_data unchanged, conflict<=1.
//  - address[1:0]!=0: access proceeds on the truncated word index, misalign<=1.
//  - Address bits above ADDR_WIDTH+1 are ignored; access wraps modulo depth.
//  - misalign and conflict are cleared only by rst.
//  - rst asserted in ACCESS or DONE: next cycle is IDLE with stall=0, even if req is still high.
//    The request is re-taken as new from IDLE on the following cycle.
// TESTING
//  1. Store then load, LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10.
//     -> each request: stall 3 cycles; lw read_data=0xDEADBEEF in its DONE cycle.
//  2. Back-to-back loads @0x0 and @0x4 (prefilled 1, 2).
//     -> stall 3, low 1, stall 3, low 1; read_data 1 then 2; no extra idle cycle.
//  3. During stall, change address to 0x20 and write_data to 0x55.
//     -> access uses the values latched in IDLE; mem[0x20] unchanged.
//  4. lw @0x13 and @(0x4+4*2**ADDR_WIDTH).
//     -> first returns word @0x10, misalign=1; second returns word @0x4.
//  5. mem_read=mem_write=1, write_data=7 @0x8.
//     -> mem[2]=7, read_data unchanged, conflict=1.
//  6. rst pulsed in ACCESS of sw 0x99 @0x30.
//     -> next cycle stall=0, all flags 0; mem[0x30]=0 after a following lw.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: latches a load/store from EX/MEM, stalls the
// pipeline for LATENCY+1 cycles, then returns registered load data as stall drops.
module dmem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall,
    output logic                  misalign,
    output logic                  conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } stateType;

    stateType               state;
    logic [CNT_W-1:0]       cnt;
    logic                   latRd;
    logic                   latWr;
    logic [ADDR_WIDTH-1:0]  latIndex;
    logic [DATA_WIDTH-1:0]  latData;
    logic                   postReset;
    logic                   req;
    logic                   unusedAddrHi;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    assign req          = mem_read | mem_write;
    assign unusedAddrHi = ^address[31:ADDR_WIDTH+2];

    // The cycle right after reset never stalls; a held request is re-taken a cycle later.
    assign stall = req && (state != DONE) && !postReset && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            latRd     <= 1'b0;
            latWr     <= 1'b0;
            latIndex  <= '0;
            latData   <= '0;
            read_data <= '0;
            misalign  <= 1'b0;
            conflict  <= 1'b0;
            postReset <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            postReset <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && !postReset) begin
                        // Write wins when both strobes are high.
                        latRd    <= mem_read && !mem_write;
                        latWr    <= mem_write;
                        latIndex <= address[ADDR_WIDTH+1:2];
                        latData  <= write_data;
                        cnt      <= CNT_W'(LATENCY - 1);
                        state    <= ACCESS;
                        if (address[1:0] != 2'b00) misalign <= 1'b1;
                        if (mem_read && mem_write)  conflict <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (latWr) begin
                            mem[latIndex] <= latData;
                        end else if (latRd) begin
                            read_data <= mem[latIndex];
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
